intersection_phase_arbiter: RTL and testbench

Four-approach intersection controller that shares one intersection among the ns, ew, sw_ne and wn_es approaches. It grants right-of-way round-robin, enforces minimum/maximum green, and sequences yellow and all-red clearance. It sits directly behind the vehicle-detector inputs and drives the four 3-bit signal heads, alongside the StopLight FSM.

---
 rtl/intersection_phase_arbiter_pkg.sv | 34 +++
 rtl/intersection_phase_arbiter_rr_pick4.sv | 25 ++
 rtl/intersection_phase_arbiter.sv | 140 ++++++++++++++
 tb/tb_intersection_phase_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_phase_arbiter_pkg.sv
// rtl/intersection_phase_arbiter_pkg.sv - shared encodings for the intersection phase arbiter
package intersection_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam logic [1:0] NS    = 2'd0;
    localparam logic [1:0] EW    = 2'd1;
    localparam logic [1:0] SW_NE = 2'd2;
    localparam logic [1:0] WN_ES = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        GREEN,
        YELLOW,
        ALL_RED
    } state_t;

    // Only the owner's head ever leaves red, so two non-red heads cannot occur.
    function automatic logic [2:0] head_light(input state_t st, input logic [1:0] owner,
                                              input logic [1:0] idx);
        logic [2:0] l;
        l = LIGHT_RED;
        if (idx == owner) begin
            if (st == GREEN)
                l = LIGHT_GRN;
            else if (st == YELLOW)
                l = LIGHT_YEL;
        end
        return l;
    endfunction

endpackage

// File: rtl/intersection_phase_arbiter_rr_pick4.sv
// rtl/intersection_phase_arbiter_rr_pick4.sv - combinational round-robin picker over four requests
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] w_cand;

    // Walk from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        valid  = 1'b0;
        idx    = last;
        w_cand = last;
        for (int i = 4; i >= 1; i--) begin
            w_cand = last + 2'(i);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// rtl/intersection_phase_arbiter.sv - four-approach round-robin intersection phase controller
module intersection_phase_arbiter
    import intersection_pkg::*;
#(
    parameter int CNT_W        = 17,
    parameter int MIN_GREEN    = 3,
    parameter int MAX_GREEN    = 6,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_traffic,
    input  logic       ew_traffic,
    input  logic       sw_ne_traffic,
    input  logic       wn_es_traffic,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] sw_ne_light,
    output logic [2:0] wn_es_light,
    output logic [3:0] grant,
    output logic       phase_done
);

    localparam logic [CNT_W-1:0] C_MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] C_MAX_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] C_YEL_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] C_AR_LAST  = CNT_W'(ALL_RED_TIME - 1);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_last, w_last_nx;
    logic [3:0][2:0]  r_light, w_light_nx;
    logic [3:0]       r_grant, w_grant_nx;
    logic             r_done, w_done_nx;

    logic [3:0] w_req;
    logic       w_pick_valid;
    logic [1:0] w_pick_idx;
    logic       w_own_req;
    logic       w_others;

    assign w_req     = {wn_es_traffic, sw_ne_traffic, ew_traffic, ns_traffic};
    assign w_own_req = w_req[r_last];
    assign w_others  = |(w_req & ~(4'b0001 << r_last));

    rr_pick4 u_pick (
        .req   (w_req),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // r_last doubles as the current owner once a phase has been granted.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nx = GREEN;
                    w_cnt_nx   = '0;
                    w_last_nx  = w_pick_idx;
                end
            end
            GREEN: begin
                if (r_cnt >= C_MIN_LAST &&
                    (!w_own_req || (w_others && r_cnt == C_MAX_LAST))) begin
                    w_state_nx = YELLOW;
                    w_cnt_nx   = '0;
                end else if (r_cnt < C_MAX_LAST) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            YELLOW: begin
                if (r_cnt == C_YEL_LAST) begin
                    w_state_nx = ALL_RED;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ALL_RED: begin
                if (r_cnt == C_AR_LAST) begin
                    w_cnt_nx = '0;
                    if (w_pick_valid) begin
                        w_state_nx = GREEN;
                        w_last_nx  = w_pick_idx;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered heads line up with it.
    always_comb begin
        w_done_nx  = (w_state_nx == ALL_RED) && (w_cnt_nx == C_AR_LAST);
        w_grant_nx = 4'b0000;
        if (w_state_nx == GREEN || w_state_nx == YELLOW)
            w_grant_nx = 4'b0001 << w_last_nx;
        w_light_nx = {4{LIGHT_RED}};
        for (int j = 0; j < 4; j++)
            w_light_nx[j] = head_light(w_state_nx, w_last_nx, 2'(j));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_light <= {4{LIGHT_RED}};
            r_grant <= 4'b0000;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_last  <= w_last_nx;
            r_light <= w_light_nx;
            r_grant <= w_grant_nx;
            r_done  <= w_done_nx;
        end
    end

    assign ns_light    = r_light[NS];
    assign ew_light    = r_light[EW];
    assign sw_ne_light = r_light[SW_NE];
    assign wn_es_light = r_light[WN_ES];
    assign grant       = r_grant;
    assign phase_done  = r_done;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// tb/tb_intersection_phase_arbiter.sv - directed self-checking bench for intersection_phase_arbiter
module tb_intersection_phase_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ns_t, ew_t, sw_t, wn_t;
    logic [2:0] ns_light, ew_light, sw_ne_light, wn_es_light;
    logic [3:0] grant;
    logic       phase_done;
    logic [3:0] green_mask;
    logic [11:0] heads;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [11:0] ALL_RED_HEADS = 12'b100_100_100_100;

    intersection_phase_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ns_traffic    (ns_t),
        .ew_traffic    (ew_t),
        .sw_ne_traffic (sw_t),
        .wn_es_traffic (wn_t),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .sw_ne_light   (sw_ne_light),
        .wn_es_light   (wn_es_light),
        .grant         (grant),
        .phase_done    (phase_done)
    );

    always #5 clk = ~clk;

    assign green_mask = {wn_es_light == GRN, sw_ne_light == GRN, ew_light == GRN, ns_light == GRN};
    assign heads      = {ns_light, ew_light, sw_ne_light, wn_es_light};

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ns_t = 1'b0; ew_t = 1'b0; sw_t = 1'b0; wn_t = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (heads !== ALL_RED_HEADS) begin
            fails++; $display("FAIL reset_heads: got %b expected %b", heads, ALL_RED_HEADS);
        end
        tests++;
        if (grant !== 4'b0000) begin
            fails++; $display("FAIL reset_grant: got %b expected 0000", grant);
        end
        tests++;
        if (phase_done !== 1'b0) begin
            fails++; $display("FAIL reset_phase_done: got %b expected 0", phase_done);
        end
    endtask

    task automatic test_uncontested_hold();
        ns_t = 1'b1;
        @(negedge clk);
        tests++;
        if (ns_light !== GRN || grant !== 4'b0001) begin
            fails++; $display("FAIL ns_latency: got light %b grant %b expected 001 0001", ns_light, grant);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (ns_light !== GRN || grant !== 4'b0001) begin
            fails++; $display("FAIL ns_hold_20: got light %b grant %b expected 001 0001", ns_light, grant);
        end
    endtask

    task automatic test_contested_max();
        int n;
        do_reset();
        ns_t = 1'b1;
        @(negedge clk);
        ew_t = 1'b1;
        n = 0;
        while (ns_light == GRN && n < 40) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n !== 6) begin
            fails++; $display("FAIL contested_green_len: got %0d expected 6", n);
        end
        tests++;
        if (ns_light !== YEL || grant !== 4'b0001) begin
            fails++; $display("FAIL contested_yellow1: got light %b grant %b expected 010 0001", ns_light, grant);
        end
        @(negedge clk);
        tests++;
        if (ns_light !== YEL) begin
            fails++; $display("FAIL contested_yellow2: got %b expected 010", ns_light);
        end
        @(negedge clk);
        tests++;
        if (heads !== ALL_RED_HEADS || phase_done !== 1'b1 || grant !== 4'b0000) begin
            fails++; $display("FAIL contested_all_red: got heads %b done %b grant %b expected %b 1 0000",
                              heads, phase_done, grant, ALL_RED_HEADS);
        end
        @(negedge clk);
        tests++;
        if (ew_light !== GRN || grant !== 4'b0010 || phase_done !== 1'b0) begin
            fails++; $display("FAIL contested_handoff: got ew %b grant %b done %b expected 001 0010 0",
                              ew_light, grant, phase_done);
        end
    endtask

    task automatic test_all_four();
        int n;
        int gap;
        logic [3:0] exp_g;
        do_reset();
        ns_t = 1'b1; ew_t = 1'b1; sw_t = 1'b1; wn_t = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            tests++;
            if (grant !== exp_g) begin
                fails++; $display("FAIL rr_order_%0d: got %b expected %b", g, grant, exp_g);
            end
            n = 0;
            while (green_mask == exp_g && n < 40) begin
                n++;
                @(negedge clk);
            end
            tests++;
            if (n !== 6) begin
                fails++; $display("FAIL rr_green_len_%0d: got %0d expected 6", g, n);
            end
            if (g < 4) begin
                gap = 0;
                while (green_mask == 4'b0000 && gap < 20) begin
                    gap++;
                    @(negedge clk);
                end
                tests++;
                if (gap !== 3) begin
                    fails++; $display("FAIL rr_gap_%0d: got %0d expected 3", g, gap);
                end
            end
        end
        ns_t = 1'b0; ew_t = 1'b0; sw_t = 1'b0; wn_t = 1'b0;
    endtask

    task automatic test_min_green();
        int n;
        do_reset();
        ns_t = 1'b1;
        @(negedge clk);
        ns_t = 1'b0;
        n = 0;
        while (ns_light == GRN && n < 40) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n !== 3) begin
            fails++; $display("FAIL min_green_len: got %0d expected 3", n);
        end
        @(negedge clk);
        tests++;
        if (ns_light !== YEL) begin
            fails++; $display("FAIL min_green_yellow2: got %b expected 010", ns_light);
        end
        @(negedge clk);
        tests++;
        if (heads !== ALL_RED_HEADS || phase_done !== 1'b1) begin
            fails++; $display("FAIL min_green_all_red: got heads %b done %b expected %b 1",
                              heads, phase_done, ALL_RED_HEADS);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (heads !== ALL_RED_HEADS || grant !== 4'b0000 || phase_done !== 1'b0) begin
            fails++; $display("FAIL min_green_idle: got heads %b grant %b done %b expected %b 0000 0",
                              heads, grant, phase_done, ALL_RED_HEADS);
        end
    endtask

    task automatic test_sole_regrant();
        do_reset();
        sw_t = 1'b1;
        @(negedge clk);
        tests++;
        if (sw_ne_light !== GRN || grant !== 4'b0100) begin
            fails++; $display("FAIL sw_grant: got light %b grant %b expected 001 0100", sw_ne_light, grant);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (sw_ne_light !== GRN) begin
            fails++; $display("FAIL sw_hold: got %b expected 001", sw_ne_light);
        end
        sw_t = 1'b0;
        @(negedge clk);
        tests++;
        if (sw_ne_light !== YEL) begin
            fails++; $display("FAIL sw_drop_yellow: got %b expected 010", sw_ne_light);
        end
        sw_t = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (phase_done !== 1'b1 || heads !== ALL_RED_HEADS) begin
            fails++; $display("FAIL sw_all_red: got done %b heads %b expected 1 %b", phase_done, heads, ALL_RED_HEADS);
        end
        @(negedge clk);
        tests++;
        if (sw_ne_light !== GRN || grant !== 4'b0100) begin
            fails++; $display("FAIL sw_regrant: got light %b grant %b expected 001 0100", sw_ne_light, grant);
        end
    endtask

    task automatic test_reset_mid_yellow();
        int n;
        do_reset();
        ew_t = 1'b1;
        @(negedge clk);
        ew_t = 1'b0;
        n = 0;
        while (ew_light !== YEL && n < 20) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (ew_light !== YEL || grant !== 4'b0010) begin
            fails++; $display("FAIL ew_yellow: got light %b grant %b expected 010 0010", ew_light, grant);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (heads !== ALL_RED_HEADS || grant !== 4'b0000 || phase_done !== 1'b0) begin
            fails++; $display("FAIL midreset_state: got heads %b grant %b done %b expected %b 0000 0",
                              heads, grant, phase_done, ALL_RED_HEADS);
        end
        rst = 1'b0;
        ns_t = 1'b1;
        ew_t = 1'b1;
        @(negedge clk);
        tests++;
        if (grant !== 4'b0001 || ns_light !== GRN) begin
            fails++; $display("FAIL midreset_ns_first: got grant %b ns %b expected 0001 001", grant, ns_light);
        end
        ns_t = 1'b0;
        ew_t = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ns_t = 1'b0; ew_t = 1'b0; sw_t = 1'b0; wn_t = 1'b0;
        test_reset();
        test_uncontested_hold();
        test_contested_max();
        test_all_four();
        test_min_green();
        test_sole_regrant();
        test_reset_mid_yellow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
